life_grid_controller: RTL and testbench

- Owns the Game-of-Life cell map and cursor that the VGA pattern generator displays.
- Replaces the fixed map and cursor constants with live registers.
- Computes the next generation serially, one cell per clock, into a shadow buffer.
- Commits the shadow buffer only at a frame boundary, so the display never shows a half-updated grid.
- Sits in the pixel-clock domain, between the debounced board buttons and the VGA pattern generator's map and cursor inputs.

---
 rtl/life_grid_pkg.sv | 5 +
 rtl/life_grid_controller_if.sv | 24 ++
 rtl/life_cell_eval.sv | 33 +++
 rtl/life_grid_controller.sv | 126 ++++++++++++
 tb/tb_life_grid_controller.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_grid_pkg.sv
// Shared types for the Game-of-Life grid controller and its cell evaluator.
package life_grid_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, WAIT_VB} state_t;
    localparam int NBR_W = 4;
endpackage

// File: rtl/life_grid_controller_if.sv
// Button/frame inputs and display-facing outputs of the grid controller.
interface life_grid_controller_if #(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10
);
    logic                       frame_tick;
    logic                       btn_up, btn_down, btn_left, btn_right;
    logic                       btn_toggle, btn_run, btn_step, btn_clear;
    logic [GRID_W*GRID_H-1:0]   cell_map;
    logic [3:0]                 cursor_h, cursor_v;
    logic                       running, busy;
    logic [15:0]                generation;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right,
               btn_toggle, btn_run, btn_step, btn_clear,
        input  cell_map, cursor_h, cursor_v, running, busy, generation
    );
    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right,
               btn_toggle, btn_run, btn_step, btn_clear,
        output cell_map, cursor_h, cursor_v, running, busy, generation
    );
endinterface

// File: rtl/life_cell_eval.sv
// Combinational B3/S23 rule for one cell; off-grid neighbours read as dead.
module life_cell_eval
    import life_grid_pkg::*;
#(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10
) (
    input  logic [GRID_W*GRID_H-1:0] map,
    input  logic [3:0]               x,
    input  logic [3:0]               y,
    output logic                     alive_next
);
    localparam int N  = GRID_W * GRID_H;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [NBR_W-1:0] nbr;
    logic             self_alive;

    always_comb begin
        nbr = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0) &&
                    int'(x) + dx >= 0 && int'(x) + dx < GRID_W &&
                    int'(y) + dy >= 0 && int'(y) + dy < GRID_H)
                    nbr = nbr + NBR_W'(map[IW'((int'(y) + dy) * GRID_W + int'(x) + dx)]);
            end
        end
    end

    assign self_alive = map[IW'(int'(y) * GRID_W + int'(x))];
    assign alive_next = (nbr == NBR_W'(3)) || (self_alive && nbr == NBR_W'(2));
endmodule

// File: rtl/life_grid_controller.sv
// Live cell map + cursor; next generation computed serially into a shadow
// buffer and committed on frame_tick so the display never sees a partial grid.
module life_grid_controller
    import life_grid_pkg::*;
#(
    parameter int                       GRID_W      = 10,
    parameter int                       GRID_H      = 10,
    parameter int                       STEP_FRAMES = 30,
    parameter logic [GRID_W*GRID_H-1:0] INIT_MAP    = '0
) (
    input logic                   clk,
    input logic                   reset_n,
    life_grid_controller_if.slave bus
);
    localparam int N  = GRID_W * GRID_H;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = $clog2(STEP_FRAMES + 1);

    state_t          state;
    logic [N-1:0]    cell_map, next_map;
    logic [IW-1:0]   idx;
    logic [3:0]      cx, cy, cur_h, cur_v;
    logic [FW-1:0]   frame_cnt;
    logic            running, busy, cell_next;
    logic [15:0]     generation;

    logic            frame_wrap, edit_ok, step_go;
    logic [IW-1:0]   cur_idx;

    // frame_wrap is the run-mode trigger point; the counter wraps there even if
    // the FSM is busy and the trigger itself is dropped.
    assign frame_wrap = bus.frame_tick && running && frame_cnt == FW'(STEP_FRAMES - 1);
    assign edit_ok    = (state == IDLE) && !running;
    assign step_go    = (state == IDLE) && ((bus.btn_step && !running) || frame_wrap);
    assign cur_idx    = IW'(int'(cur_v) * GRID_W + int'(cur_h));

    life_cell_eval #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_eval (
        .map        (cell_map),
        .x          (cx),
        .y          (cy),
        .alive_next (cell_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cell_map   <= INIT_MAP;
            next_map   <= '0;
            idx        <= '0;
            cx         <= '0;
            cy         <= '0;
            cur_h      <= '0;
            cur_v      <= '0;
            frame_cnt  <= '0;
            running    <= 1'b0;
            busy       <= 1'b0;
            generation <= '0;
        end else begin
            if (bus.btn_up && !bus.btn_down)
                cur_v <= (cur_v == 4'd0) ? 4'(GRID_H - 1) : cur_v - 4'd1;
            else if (bus.btn_down && !bus.btn_up)
                cur_v <= (cur_v == 4'(GRID_H - 1)) ? 4'd0 : cur_v + 4'd1;
            if (bus.btn_left && !bus.btn_right)
                cur_h <= (cur_h == 4'd0) ? 4'(GRID_W - 1) : cur_h - 4'd1;
            else if (bus.btn_right && !bus.btn_left)
                cur_h <= (cur_h == 4'(GRID_W - 1)) ? 4'd0 : cur_h + 4'd1;

            if (bus.btn_run)
                running <= !running;
            if (bus.btn_run && !running)
                frame_cnt <= '0;
            else if (frame_wrap)
                frame_cnt <= '0;
            else if (bus.frame_tick && running)
                frame_cnt <= frame_cnt + FW'(1);

            case (state)
                IDLE: begin
                    if (edit_ok && bus.btn_clear) begin
                        cell_map   <= '0;
                        generation <= '0;
                    end else if (edit_ok && bus.btn_toggle) begin
                        cell_map[cur_idx] <= ~cell_map[cur_idx];
                    end
                    if (step_go) begin
                        state <= COMPUTE;
                        busy  <= 1'b1;
                        idx   <= '0;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                COMPUTE: begin
                    next_map[idx] <= cell_next;
                    if (idx == IW'(N - 1)) begin
                        state <= WAIT_VB;
                    end else begin
                        idx <= idx + IW'(1);
                        if (cx == 4'(GRID_W - 1)) begin
                            cx <= '0;
                            cy <= cy + 4'd1;
                        end else begin
                            cx <= cx + 4'd1;
                        end
                    end
                end
                WAIT_VB: begin
                    if (bus.frame_tick) begin
                        cell_map   <= next_map;
                        generation <= generation + 16'd1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cell_map   = cell_map;
    assign bus.cursor_h   = cur_h;
    assign bus.cursor_v   = cur_v;
    assign bus.running    = running;
    assign bus.busy       = busy;
    assign bus.generation = generation;
endmodule

// File: tb/tb_life_grid_controller.sv
// Self-checking bench: cursor vector table plus a generation scoreboard fed by a life model.
module tb_life_grid_controller;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int N  = W * H;
    localparam int SF = 3;
    localparam logic [N-1:0] INIT = 100'd1;

    localparam logic [8:0] B_UP = 9'd1,  B_DN = 9'd2,   B_LF = 9'd4,   B_RT = 9'd8;
    localparam logic [8:0] B_TG = 9'd16, B_RUN = 9'd32, B_STEP = 9'd64, B_CLR = 9'd128;
    localparam logic [8:0] B_FT = 9'd256;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    life_grid_controller_if #(.GRID_W(W), .GRID_H(H)) bus ();

    life_grid_controller #(.GRID_W(W), .GRID_H(H), .STEP_FRAMES(SF), .INIT_MAP(INIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [N-1:0] map;
        logic [15:0]  gen;
    } sb_t;

    typedef struct {
        logic [8:0] btn;
        logic [3:0] h;
        logic [3:0] v;
    } cur_vec_t;

    sb_t          sb_q[$];
    cur_vec_t     cv[9];
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] model_map;
    logic [15:0]  model_gen;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] b);
        bus.btn_up     = b[0];
        bus.btn_down   = b[1];
        bus.btn_left   = b[2];
        bus.btn_right  = b[3];
        bus.btn_toggle = b[4];
        bus.btn_run    = b[5];
        bus.btn_step   = b[6];
        bus.btn_clear  = b[7];
        bus.frame_tick = b[8];
    endtask

    task automatic press(input logic [8:0] b);
        drive(b);
        cyc(1);
        drive('0);
    endtask

    function automatic logic [N-1:0] life_next(input logic [N-1:0] m);
        bit p [0:H+1][0:W+1];
        logic [N-1:0] r;
        int cnt;
        for (int j = 0; j < H + 2; j++)
            for (int i = 0; i < W + 2; i++)
                p[j][i] = 1'b0;
        for (int j = 0; j < H; j++)
            for (int i = 0; i < W; i++)
                p[j+1][i+1] = m[j*W+i];
        r = '0;
        for (int j = 1; j <= H; j++) begin
            for (int i = 1; i <= W; i++) begin
                cnt = int'(p[j-1][i-1]) + int'(p[j-1][i]) + int'(p[j-1][i+1]) +
                      int'(p[j][i-1])                     + int'(p[j][i+1]) +
                      int'(p[j+1][i-1]) + int'(p[j+1][i]) + int'(p[j+1][i+1]);
                r[(j-1)*W+(i-1)] = (cnt == 3) || (p[j][i] && cnt == 2);
            end
        end
        return r;
    endfunction

    task automatic goto_cell(input int x, input int y);
        for (int i = 0; i < 16 && int'(bus.cursor_h) != x; i++) press(B_RT);
        for (int i = 0; i < 16 && int'(bus.cursor_v) != y; i++) press(B_DN);
    endtask

    task automatic set_cell(input int x, input int y);
        goto_cell(x, y);
        press(B_TG);
        model_map[y*W+x] = ~model_map[y*W+x];
    endtask

    task automatic clear_all();
        press(B_CLR | B_TG);
        model_map = '0;
        model_gen = '0;
        chk("clear_map", bus.cell_map, model_map);
        chk("clear_gen", bus.generation, model_gen);
    endtask

    task automatic push_expected();
        model_map = life_next(model_map);
        model_gen = model_gen + 16'd1;
        sb_q.push_back('{model_map, model_gen});
    endtask

    task automatic commit_check(input string name);
        sb_t e;
        press(B_FT);
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: got commit expected queued entry", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_map"}, bus.cell_map, e.map);
            chk({name, "_gen"}, bus.generation, e.gen);
            chk({name, "_busy_end"}, bus.busy, 1'b0);
        end
    endtask

    // Step with a probe frame_tick on the last COMPUTE cycle, which must be ignored.
    task automatic step_and_commit(input string name);
        logic [N-1:0] prev;
        prev = model_map;
        press(B_STEP);
        chk({name, "_busy_start"}, bus.busy, 1'b1);
        push_expected();
        cyc(10);
        press(B_TG);
        chk({name, "_frozen"}, bus.cell_map, prev);
        cyc(88);
        press(B_FT);
        chk({name, "_len_gen"}, bus.generation, model_gen - 16'd1);
        chk({name, "_len_busy"}, bus.busy, 1'b1);
        commit_check(name);
    endtask

    task automatic run_tick();
        press(B_FT);
        cyc(20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] ref_map;
        drive('0);
        reset_n = 1'b0;
        cyc(2);
        chk("rst_map", bus.cell_map, INIT);
        chk("rst_h", bus.cursor_h, 4'd0);
        chk("rst_v", bus.cursor_v, 4'd0);
        chk("rst_gen", bus.generation, 16'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_run", bus.running, 1'b0);
        reset_n = 1'b1;
        cyc(2);
        model_map = INIT;
        model_gen = '0;

        cv[0] = '{B_LF,        4'd9, 4'd0};
        cv[1] = '{B_UP,        4'd9, 4'd9};
        cv[2] = '{B_UP | B_DN, 4'd9, 4'd9};
        cv[3] = '{B_LF | B_RT, 4'd9, 4'd9};
        cv[4] = '{B_RT,        4'd0, 4'd9};
        cv[5] = '{B_DN,        4'd0, 4'd0};
        cv[6] = '{B_DN | B_RT, 4'd1, 4'd1};
        cv[7] = '{B_UP | B_LF, 4'd0, 4'd0};
        cv[8] = '{B_RT,        4'd1, 4'd0};
        for (int i = 0; i < 9; i++) begin
            press(cv[i].btn);
            chk($sformatf("cursor%0d_h", i), bus.cursor_h, cv[i].h);
            chk($sformatf("cursor%0d_v", i), bus.cursor_v, cv[i].v);
        end

        // Toggle applies at (1,0), before the simultaneous move to (2,0).
        press(B_TG | B_RT);
        model_map[1] = 1'b1;
        chk("toggle_move_map", bus.cell_map, model_map);
        chk("toggle_move_h", bus.cursor_h, 4'd2);

        clear_all();
        set_cell(4, 5);
        set_cell(5, 5);
        set_cell(6, 5);
        chk("blinker_set", bus.cell_map, model_map);
        step_and_commit("blinker1");
        ref_map = '0;
        ref_map[45] = 1'b1;
        ref_map[55] = 1'b1;
        ref_map[65] = 1'b1;
        chk("blinker_vertical", bus.cell_map, ref_map);

        press(B_RUN);
        chk("run_on", bus.running, 1'b1);
        run_tick();
        press(B_STEP);
        chk("step_ignored_running", bus.busy, 1'b0);
        press(B_TG);
        chk("toggle_ignored_running", bus.cell_map, model_map);
        run_tick();
        chk("tick2_no_trigger", bus.busy, 1'b0);
        press(B_FT);
        push_expected();
        chk("tick3_trigger", bus.busy, 1'b1);
        chk("tick3_gen", bus.generation, 16'd1);
        cyc(120);
        commit_check("run_commit1");
        cyc(20);
        run_tick();
        chk("tick5_no_trigger", bus.busy, 1'b0);
        press(B_FT);
        push_expected();
        chk("tick6_trigger", bus.busy, 1'b1);
        cyc(120);
        commit_check("run_commit2");
        chk("run_gen3", bus.generation, 16'd3);
        press(B_RUN);
        chk("run_off", bus.running, 1'b0);

        clear_all();
        set_cell(0, 0);
        set_cell(1, 0);
        set_cell(0, 1);
        set_cell(1, 1);
        ref_map = model_map;
        for (int i = 0; i < 5; i++) step_and_commit($sformatf("block%0d", i));
        chk("block_stable", bus.cell_map, ref_map);

        clear_all();
        for (int i = 0; i < N; i++)
            if ($urandom_range(0, 2) == 0) set_cell(i % W, i / W);
        for (int i = 0; i < 4; i++) step_and_commit($sformatf("rand%0d", i));

        press(B_RT);
        press(B_DN);
        press(B_STEP);
        cyc(50);
        reset_n = 1'b0;
        #2;
        chk("midrst_map", bus.cell_map, INIT);
        chk("midrst_h", bus.cursor_h, 4'd0);
        chk("midrst_v", bus.cursor_v, 4'd0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_run", bus.running, 1'b0);
        chk("midrst_gen", bus.generation, 16'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        sb_q.delete();
        model_map = INIT;
        model_gen = '0;
        step_and_commit("after_rst");
        chk("after_rst_empty", bus.cell_map, 100'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
